vlsu_req_sched: RTL and testbench

VLSU_REQ_SCHED -- requirements
Module: vlsu_req_sched

---
 rtl/vlsu_req_sched.sv | 126 ++++++++++++
 tb/tb_vlsu_req_sched.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/vlsu_req_sched.sv
// ----------------------------------------------------------------------------
// vlsu_req_sched : load/store request arbiter feeding one registered VLSU slot
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vlsu_req_sched #(
  parameter int unsigned MaxStOutstanding = 4,
  parameter bit          StrictOrder      = 1'b1,
  parameter type         vlsu_req_t       = logic
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      ld_req_valid_i,
  output logic      ld_req_ready_o,
  input  vlsu_req_t ld_req_i,
  input  logic      st_req_valid_i,
  output logic      st_req_ready_o,
  input  vlsu_req_t st_req_i,
  output logic      vlsu_req_valid_o,
  input  logic      vlsu_req_ready_i,
  output vlsu_req_t vlsu_req_o,
  input  logic      st_done_i,
  output logic      st_pending_o
);

  localparam int unsigned            c_cnt_w   = $clog2(MaxStOutstanding + 1);
  localparam logic [c_cnt_w-1:0]     c_cnt_max = c_cnt_w'(MaxStOutstanding);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e             r_state;
  logic               r_is_store;
  logic               r_last_store;
  logic [c_cnt_w-1:0] r_cnt;
  vlsu_req_t          r_payload;

  logic w_can_load;
  logic w_buffered_store;
  logic w_st_elig;
  logic w_ld_elig;
  logic w_grant_st;
  logic w_grant_ld;
  logic w_grant;
  logic w_drain;
  logic w_cnt_dec;

  assign w_can_load       = (r_state == ST_EMPTY) || vlsu_req_ready_i;
  assign w_buffered_store = (r_state == ST_FULL) && r_is_store;
  assign w_st_elig        = st_req_valid_i && (r_cnt < c_cnt_max);

  generate
    if (StrictOrder) begin : g_strict
      assign w_ld_elig = ld_req_valid_i && (r_cnt == '0) && !w_buffered_store;
    end else begin : g_relaxed
      assign w_ld_elig = ld_req_valid_i;
    end
  endgenerate

  // Round-robin on contention: the source not granted most recently wins.
  always_comb begin
    w_grant_st = 1'b0;
    w_grant_ld = 1'b0;
    if (rst_ni && w_can_load) begin
      if (w_st_elig && w_ld_elig) begin
        w_grant_ld = r_last_store;
        w_grant_st = !r_last_store;
      end else begin
        w_grant_st = w_st_elig;
        w_grant_ld = w_ld_elig;
      end
    end
  end

  assign w_grant   = w_grant_st || w_grant_ld;
  assign w_drain   = (r_state == ST_FULL) && vlsu_req_ready_i;
  assign w_cnt_dec = st_done_i && (r_cnt != '0);

  assign ld_req_ready_o   = w_grant_ld;
  assign st_req_ready_o   = w_grant_st;
  assign vlsu_req_valid_o = (r_state == ST_FULL);
  assign vlsu_req_o       = r_payload;
  assign st_pending_o     = (r_cnt != '0) || w_buffered_store;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ST_EMPTY;
      r_is_store   <= 1'b0;
      r_last_store <= 1'b1;
      r_cnt        <= '0;
    end else begin
      if (w_grant) begin
        r_state      <= ST_FULL;
        r_is_store   <= w_grant_st;
        r_last_store <= w_grant_st;
      end else if (w_drain) begin
        r_state <= ST_EMPTY;
      end

      if (w_grant_st && !w_cnt_dec) begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end else if (w_cnt_dec && !w_grant_st) begin
        r_cnt <= r_cnt - c_cnt_w'(1);
      end
    end
  end

  // Payload needs no reset: it is only observed while the slot is FULL.
  always_ff @(posedge clk_i) begin
    if (w_grant) begin
      r_payload <= w_grant_st ? st_req_i : ld_req_i;
    end
  end

`ifndef SYNTHESIS
  a_no_done_underflow : assert property (
    @(posedge clk_i) disable iff (!rst_ni) st_done_i |-> (r_cnt != '0)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_vlsu_req_sched.sv
// ----------------------------------------------------------------------------
// tb_vlsu_req_sched : directed + random bench with a transaction-level model
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_vlsu_req_sched;

  localparam int MAXST = 4;

  typedef struct {
    logic [15:0] pay;
    bit          is_st;
  } slot_t;

  logic        clk;
  logic        rst_n;
  logic        ld_v, st_v, rdy_i, st_done;
  logic [15:0] ld_p, st_p;
  logic        ld_rdy, st_rdy, out_v, pend;
  logic [15:0] out_p;

  int    n_vec;
  int    n_err;
  slot_t slot_q[$];
  int    m_cnt;
  bit    m_last_st;
  int    st_grants;

  vlsu_req_sched #(
    .MaxStOutstanding(MAXST),
    .StrictOrder     (1'b1),
    .vlsu_req_t      (logic [15:0])
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .ld_req_valid_i  (ld_v),
    .ld_req_ready_o  (ld_rdy),
    .ld_req_i        (ld_p),
    .st_req_valid_i  (st_v),
    .st_req_ready_o  (st_rdy),
    .st_req_i        (st_p),
    .vlsu_req_valid_o(out_v),
    .vlsu_req_ready_i(rdy_i),
    .vlsu_req_o      (out_p),
    .st_done_i       (st_done),
    .st_pending_o    (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check grant decision, advance, check slot state.
  task automatic step(input bit lv, input bit sv, input bit rdy, input bit dn);
    bit can, st_ok, ld_ok, gs, gl, full;
    slot_t s;
    @(negedge clk);
    ld_v    = lv;
    st_v    = sv;
    rdy_i   = rdy;
    st_done = dn && (m_cnt > 0);
    ld_p    = 16'($urandom);
    st_p    = 16'($urandom);
    #1;
    full  = (slot_q.size() != 0);
    can   = !full || rdy;
    st_ok = sv && (m_cnt < MAXST);
    ld_ok = lv && (m_cnt == 0) && !(full && slot_q[0].is_st);
    gs = 1'b0;
    gl = 1'b0;
    if (can) begin
      if (st_ok && ld_ok) begin
        if (m_last_st) gl = 1'b1; else gs = 1'b1;
      end else begin
        gs = st_ok;
        gl = ld_ok;
      end
    end
    chk("ld_ready", {31'd0, ld_rdy}, {31'd0, gl});
    chk("st_ready", {31'd0, st_rdy}, {31'd0, gs});
    if (full && rdy) begin
      chk("handshake_payload", {16'd0, out_p}, {16'd0, slot_q[0].pay});
      void'(slot_q.pop_front());
    end
    @(posedge clk);
    if (gs || gl) begin
      s.pay   = gs ? st_p : ld_p;
      s.is_st = gs;
      slot_q.push_back(s);
      m_last_st = gs;
    end
    if (gs) st_grants++;
    m_cnt = m_cnt + (gs ? 1 : 0) - (st_done ? 1 : 0);
    #1;
    full = (slot_q.size() != 0);
    chk("out_valid", {31'd0, out_v}, {31'd0, full});
    if (full) chk("out_payload", {16'd0, out_p}, {16'd0, slot_q[0].pay});
    chk("st_pending", {31'd0, pend}, {31'd0, (m_cnt != 0) || (full && slot_q[0].is_st)});
  endtask

  task automatic do_reset();
    @(negedge clk);
    ld_v  = 1'b1;
    st_v  = 1'b1;
    rdy_i = 1'b1;
    st_done = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, out_v}, 32'd0);
    chk("rst_pending", {31'd0, pend}, 32'd0);
    chk("rst_ld_ready", {31'd0, ld_rdy}, 32'd0);
    chk("rst_st_ready", {31'd0, st_rdy}, 32'd0);
    slot_q.delete();
    m_cnt     = 0;
    m_last_st = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_hold_st_ready", {31'd0, st_rdy}, 32'd0);
    ld_v  = 1'b0;
    st_v  = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0; n_err = 0; m_cnt = 0; m_last_st = 1'b1; st_grants = 0;
    rst_n = 1'b0; ld_v = 1'b0; st_v = 1'b0; rdy_i = 1'b0; st_done = 1'b0;
    ld_p = '0; st_p = '0;
    do_reset();

    // Both sources valid from reset: load first, then store, then stores only.
    repeat (6) step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("first_store_cap", st_grants, 32'd4);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (4) step(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0);

    // Store-only saturation, then one completion releases exactly one grant.
    do_reset();
    st_grants = 0;
    repeat (8) step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("sat_grants", st_grants, 32'd4);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("sat_one_more", st_grants, 32'd5);

    // Completion and grant in the same cycle at cnt=2.
    do_reset();
    repeat (2) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0);

    // Back-pressure with a full slot, then drain and refill without a bubble.
    do_reset();
    step(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0);

    // Reset while FULL with three stores in flight.
    do_reset();
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
